// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches decoded controls and operands, extends the
// immediate, inserts bubbles on flush and flags load-use hazards.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [2:0]        id_ALUOp,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm16,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic              ex_valid,
  output logic [2:0]        ex_ALUOp,
  output logic [5:0]        ex_funct,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [2:0]        alu_op;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              reg_dst;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } ex_t;

  ex_t              ex_q, ex_d, id_pkt;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             zero_ext;

  // andi/ori use a logical (zero-extended) immediate; everything else is signed
  assign zero_ext = (id_ALUOp == 3'b000) || (id_ALUOp == 3'b001);

  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = id_valid;
    id_pkt.alu_op     = id_ALUOp;
    id_pkt.reg_write  = id_RegWrite;
    id_pkt.mem_to_reg = id_MemtoReg;
    id_pkt.mem_read   = id_MemRead;
    id_pkt.mem_write  = id_MemWrite;
    id_pkt.branch     = id_Branch;
    id_pkt.alu_src    = id_ALUSrc;
    id_pkt.reg_dst    = id_RegDst;
    id_pkt.pc_plus4   = id_pc_plus4;
    id_pkt.rs_data    = id_rs_data;
    id_pkt.rt_data    = id_rt_data;
    id_pkt.imm_ext    = {{(DATA_W-16){id_imm16[15] & ~zero_ext}}, id_imm16};
    id_pkt.rs         = id_rs;
    id_pkt.rt         = id_rt;
    id_pkt.rd         = id_rd;
  end

  // flush beats stall; a bubble is an all-zero packet
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (!stall) begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_funct    = ex_q.imm_ext[5:0];
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemtoReg = ex_q.mem_to_reg;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_Branch   = ex_q.branch;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_RegDst   = ex_q.reg_dst;
  assign ex_pc_plus4 = ex_q.pc_plus4;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm_ext  = ex_q.imm_ext;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign bubble_cnt  = bubble_cnt_q;

  // $zero is never a real dependency, so rt==0 loads never hazard
  assign load_use_hazard = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rt != 5'd0) &
                           ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus queues expected ex_ state,
// a monitor compares it one cycle later.
module tb_id_ex_pipe_reg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [2:0] id_ALUOp = '0;
  logic id_RegWrite = 0, id_MemtoReg = 0, id_MemRead = 0, id_MemWrite = 0;
  logic id_Branch = 0, id_ALUSrc = 0, id_RegDst = 0;
  logic [DATA_W-1:0] id_pc_plus4 = '0, id_rs_data = '0, id_rt_data = '0;
  logic [15:0] id_imm16 = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUSrc, ex_RegDst;
  logic [2:0] ex_ALUOp;
  logic [5:0] ex_funct;
  logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic load_use_hazard;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_ALUOp(id_ALUOp), .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
    .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_funct(ex_funct),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegDst(ex_RegDst), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .load_use_hazard(load_use_hazard), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // ctrl bits: RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst
  typedef struct packed {
    logic valid; logic [2:0] aluop; logic [6:0] ctrl;
    logic [31:0] pc, rsd, rtd; logic [15:0] imm; logic [4:0] rs, rt, rd;
  } vin_t;
  typedef struct packed {
    logic valid; logic [2:0] aluop; logic [5:0] funct; logic [6:0] ctrl;
    logic [31:0] pc, rsd, rtd, imm; logic [4:0] rs, rt, rd; logic [3:0] cnt;
  } vout_t;

  vout_t exp_q[$];
  string name_q[$];
  vout_t last_exp = '0;
  int n_checks = 0, n_pass = 0;

  function automatic vout_t actual();
    return {ex_valid, ex_ALUOp, ex_funct,
            {ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUSrc, ex_RegDst},
            ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, bubble_cnt};
  endfunction

  function automatic vin_t mk(input logic v, input logic [2:0] op, input logic [6:0] ctrl,
                              input logic [15:0] imm, input logic [4:0] rs, rt, rd, input int seed);
    vin_t r;
    r = {v, op, ctrl, 32'h0040_0000 + 32'(seed * 4), 32'hA000_0000 | 32'(seed),
         32'h0B00_0000 | 32'(seed), imm, rs, rt, rd};
    return r;
  endfunction

  task automatic chk_out(input string nm, input vout_t act, input vout_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // drive one cycle at negedge; hazard is checked against the current ex_ state
  task automatic cyc(input vin_t in, input bit st, input bit fl, input logic [31:0] eimm,
                     input logic [3:0] ecnt, input bit ehaz, input string nm);
    vout_t e;
    @(negedge clk);
    id_valid = in.valid; id_ALUOp = in.aluop;
    {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_RegDst} = in.ctrl;
    id_pc_plus4 = in.pc; id_rs_data = in.rsd; id_rt_data = in.rtd; id_imm16 = in.imm;
    id_rs = in.rs; id_rt = in.rt; id_rd = in.rd;
    stall = st; flush = fl;
    if (fl) e = '0;
    else if (st) e = last_exp;
    else e = {in.valid, in.aluop, eimm[5:0], in.ctrl, in.pc, in.rsd, in.rtd, eimm,
              in.rs, in.rt, in.rd, 4'h0};
    e.cnt = ecnt;
    last_exp = e;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1 chk_bit({nm, "_haz"}, load_use_hazard, ehaz);
  endtask

  // monitor: ex_ state produced by the edge just taken
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk_out(name_q.pop_front(), actual(), exp_q.pop_front());
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vin_t z;
    z = '0;
    #3;
    chk_out("reset_init", actual(), '0);
    chk_bit("reset_init_haz", load_use_hazard, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    cyc(mk(1, 3'b010, 7'b1000010, 16'hFFFC, 1, 2, 3, 1), 0, 0, 32'hFFFF_FFFC, 0, 0, "sext_neg");
    cyc(mk(1, 3'b001, 7'b1000010, 16'h8025, 4, 5, 0, 2), 0, 0, 32'h0000_8025, 0, 0, "zext_ori");
    cyc(mk(1, 3'b000, 7'b1000010, 16'h8001, 6, 7, 0, 3), 0, 0, 32'h0000_8001, 0, 0, "zext_andi");
    cyc(mk(1, 3'b100, 7'b1000001, 16'h002A, 1, 2, 3, 4), 0, 0, 32'h0000_002A, 0, 0, "rtype");
    cyc(mk(1, 3'b011, 7'b1000010, 16'h7FFF, 2, 3, 0, 5), 0, 0, 32'h0000_7FFF, 0, 0, "sext_pos");
    cyc(mk(1, 3'b010, 7'b1110010, 16'h0004, 9, 8, 0, 6), 0, 0, 32'h0000_0004, 0, 0, "lw_rt8");
    cyc(mk(1, 3'b100, 7'b1000001, 16'h0020, 8, 5, 10, 7), 0, 1, 32'h0, 1, 1, "lu_rs_flush");
    cyc(mk(1, 3'b010, 7'b1110010, 16'h0010, 3, 0, 0, 8), 0, 0, 32'h0000_0010, 1, 0, "lw_rt0");
    cyc(mk(1, 3'b100, 7'b1000001, 16'h0024, 0, 0, 4, 9), 0, 0, 32'h0000_0024, 1, 0, "after_rt0");
    cyc(mk(1, 3'b010, 7'b1110010, 16'hFFF0, 3, 8, 0, 10), 0, 0, 32'hFFFF_FFF0, 1, 0, "lw_rt8b");
    cyc(mk(0, 3'b100, 7'b1000001, 16'h0000, 8, 1, 1, 11), 1, 0, 32'h0, 1, 0, "idle_stall");
    cyc(mk(1, 3'b100, 7'b1000001, 16'h0020, 4, 8, 12, 12), 0, 0, 32'h0000_0020, 1, 1, "lu_rt");
    cyc(mk(1, 3'b011, 7'b1000010, 16'hABCD, 5, 6, 0, 13), 0, 0, 32'hFFFF_ABCD, 1, 0, "stall_base");
    for (int i = 0; i < 3; i++)
      cyc(mk(1, 3'b010, 7'b1110010, 16'h1234 + 16'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 20 + i),
          1, 0, 32'h0, 1, 0, "stall_hold");
    cyc(mk(1, 3'b100, 7'b1000001, 16'h0022, 1, 2, 3, 30), 1, 1, 32'h0, 2, 0, "stall_flush");
    for (int i = 0; i < 20; i++)
      cyc(z, 0, 1, 32'h0, (i + 3 > 15) ? 4'd15 : 4'(i + 3), 0, "saturate");
    cyc(mk(1, 3'b010, 7'b0000000, 16'h0001, 7, 9, 11, 40), 0, 0, 32'h0000_0001, 15, 0, "pre_reset");

    // asynchronous reset mid-cycle while stall and flush are both asserted
    @(negedge clk);
    stall = 1'b1; flush = 1'b1; id_valid = 1'b1; id_ALUOp = 3'b100; id_imm16 = 16'h00FF;
    #2 rst_n = 1'b0;
    #1;
    chk_out("reset_async", actual(), '0);
    @(negedge clk);
    chk_out("reset_hold", actual(), '0);
    stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_ALUOp = '0; id_imm16 = '0;
    {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_RegDst} = '0;
    id_pc_plus4 = '0; id_rs_data = '0; id_rt_data = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    rst_n = 1'b1;
    last_exp = '0;
    cyc(z, 0, 1, 32'h0, 1, 0, "post_reset_flush");
    cyc(mk(1, 3'b000, 7'b1000010, 16'hFFFF, 2, 4, 0, 50), 0, 0, 32'h0000_FFFF, 1, 0, "post_reset_load");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
